// File: rtl/cpu_hs_pkg.sv
// Shared types and helpers for the CPU-side multi-channel handshake transmitter.
package cpu_hs_pkg;

  // Per-channel handshake phase.
  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WAIT_LOW
  } hs_state_t;

  // Bits needed to encode v distinct values, never less than one.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/hs_tx_channel.sv
// One transmit channel: word FIFO, ack synchroniser, four-phase send/ack FSM,
// SEND timeout timer and sticky timeout error flag.
module hs_tx_channel
  import cpu_hs_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  output logic              push_ready_o,
  input  logic              ack_i,
  input  logic              err_clr_i,
  output logic              send_o,
  output logic [DATA_W-1:0] data_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned AW = clog2_min1(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = clog2_min1(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_MAX  = '1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q;
  logic [AW-1:0]     wr_ptr_q;
  logic [CW-1:0]     cnt_q;
  logic              ack_meta_q;
  logic              ack_s_q;
  hs_state_t         state_q;
  logic [TW-1:0]     tmr_q;
  logic              send_q;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic              not_full;
  logic              wr_en;
  logic              rd_en;
  logic              timeout_hit;

  // Push acceptance, pop on handshake completion or abort, and busy status.
  always_comb begin
    not_full    = (cnt_q != FULL_CNT);
    wr_en       = push_i && not_full;
    timeout_hit = (TIMEOUT != 0) && (state_q == SEND) && !ack_s_q && (tmr_q == TMR_LAST);
    rd_en       = (state_q == SEND) && (ack_s_q || timeout_hit);
    busy_o      = (state_q != IDLE) || (cnt_q != '0);
  end

  // Two-flop synchroniser for the peripheral ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= ack_i;
      ack_s_q    <= ack_meta_q;
    end
  end

  // FIFO storage; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Handshake FSM with registered send strobe, data, timer and sticky error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      send_q  <= 1'b0;
      data_q  <= '0;
      tmr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((cnt_q != '0) && !ack_s_q) begin
            data_q  <= mem_q[rd_ptr_q];
            send_q  <= 1'b1;
            tmr_q   <= '0;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (rd_en) begin
            send_q  <= 1'b0;
            state_q <= WAIT_LOW;
          end else if (tmr_q != TMR_MAX) begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        WAIT_LOW: begin
          if (!ack_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      // A timeout on the same edge as a clear request keeps the flag set.
      if (timeout_hit)    err_q <= 1'b1;
      else if (err_clr_i) err_q <= 1'b0;
    end
  end

  assign push_ready_o = not_full;
  assign send_o       = send_q;
  assign data_o       = data_q;
  assign err_o        = err_q;

endmodule

// File: rtl/cpu_handshake_tx.sv
// Multi-channel CPU-side transmit engine: demultiplexes the push port onto
// independent handshake channels and packs their data outputs.
module cpu_handshake_tx
  import cpu_hs_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                           clkCPU,
  input  logic                           rst,
  input  logic                           push_valid,
  input  logic [clog2_min1(CHANNELS)-1:0] push_ch,
  input  logic [DATA_W-1:0]              push_data,
  output logic [CHANNELS-1:0]            push_ready,
  output logic [CHANNELS-1:0]            outsend,
  output logic [CHANNELS*DATA_W-1:0]     outdata,
  input  logic [CHANNELS-1:0]            ack,
  output logic [CHANNELS-1:0]            err,
  input  logic [CHANNELS-1:0]            err_clr,
  output logic [CHANNELS-1:0]            busy
);

  localparam int unsigned CHW = clog2_min1(CHANNELS);

  // An out-of-range channel index selects no channel, so the word is dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic sel;
    assign sel = push_valid && (push_ch == CHW'(g));

    hs_tx_channel #(
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
    ) u_chan (
      .clk_i        (clkCPU),
      .rst_i        (rst),
      .push_i       (sel),
      .push_data_i  (push_data),
      .push_ready_o (push_ready[g]),
      .ack_i        (ack[g]),
      .err_clr_i    (err_clr[g]),
      .send_o       (outsend[g]),
      .data_o       (outdata[g*DATA_W +: DATA_W]),
      .err_o        (err[g]),
      .busy_o       (busy[g])
    );
  end

endmodule
